// File: rtl/tone_map_stream.sv
// tone_map_stream: global Reinhard tone mapper that packs mapped pixels into RAM words.
// Ports: clk, rst_n (sync, active low); in_valid/in_data/in_ready pixel stream;
//   frame_done end-of-frame pulse; tm_en map (1) or bypass (0);
//   ram_busy/wr_req/wr_data RAM write port; frame_cnt completed frames.
module tone_map_stream #(
    parameter int IN_W      = 12,
    parameter int CH        = 3,
    parameter int OUT_W     = 5,
    parameter int PIX_W     = 16,
    parameter int WORD_W    = 128,
    parameter int LOG2_NPIX = 19,
    parameter int A_Q8      = 46
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [CH*IN_W-1:0] in_data,
    output logic               in_ready,
    input  logic               frame_done,
    input  logic               tm_en,
    input  logic               ram_busy,
    output logic               wr_req,
    output logic [WORD_W-1:0]  wr_data,
    output logic [7:0]         frame_cnt
);
    localparam int PPW    = WORD_W / PIX_W;
    localparam int SLOT_W = $clog2(PPW + 1);
    localparam int SUM_W  = IN_W + LOG2_NPIX + 1;
    localparam int MEAN_W = SUM_W - LOG2_NPIX;
    localparam int NUM_W  = IN_W + 8;
    localparam int DEN_W  = NUM_W + 2;
    localparam int REM_W  = DEN_W + OUT_W;
    localparam int CNT_W  = $clog2(OUT_W + 1);
    localparam logic [OUT_W-1:0]  MAXO = '1;
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(PPW - 1);

    typedef enum logic [2:0] {IDLE, DIV, PACK, WRITE, FLUSH} state_t;

    state_t             st;
    logic               rdy_q;
    logic               pend;
    logic               from_flush;
    logic               fin;
    logic [SLOT_W-1:0]  slot;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  hold;
    logic [WORD_W-1:0]  hold_nx;
    logic [PIX_W-1:0]   pix;
    logic [SUM_W-1:0]   sum     [CH];
    logic [MEAN_W-1:0]  mean    [CH];
    logic [REM_W-1:0]   rem     [CH];
    logic [REM_W-1:0]   dsh     [CH];
    logic [OUT_W-1:0]   q       [CH];
    logic [IN_W-1:0]    e       [CH];
    logic [NUM_W-1:0]   num     [CH];
    logic [DEN_W-1:0]   den     [CH];
    logic [SUM_W:0]     sum_add [CH];

    // rdy_q keeps in_ready low while reset is held and for the release cycle
    assign in_ready = rdy_q && (st == IDLE) && !pend;
    assign wr_req   = (st == WRITE) && !ram_busy;
    // end of frame: empty flush, or the partial-word write issued by FLUSH
    assign fin      = ((st == FLUSH) && (slot == '0)) || (wr_req && from_flush);

    always_comb begin
        pix = '0;
        for (int c = 0; c < CH; c++) begin
            e[c]       = in_data[(CH-1-c)*IN_W +: IN_W];
            num[c]     = NUM_W'(A_Q8) * NUM_W'(e[c]);
            den[c]     = DEN_W'({mean[c], 8'd0}) + DEN_W'(num[c]);
            sum_add[c] = {1'b0, sum[c]} + (SUM_W+1)'(e[c]);
            pix[PIX_W-1-c*OUT_W -: OUT_W] = q[c];
        end
        hold_nx = hold;
        for (int s = 0; s < PPW; s++) begin
            if (slot == SLOT_W'(s)) hold_nx[s*PIX_W +: PIX_W] = pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            rdy_q      <= 1'b0;
            pend       <= 1'b0;
            from_flush <= 1'b0;
            slot       <= '0;
            cnt        <= '0;
            hold       <= '0;
            wr_data    <= '0;
            frame_cnt  <= '0;
            for (int c = 0; c < CH; c++) begin
                sum[c]  <= '0;
                mean[c] <= '0;
                rem[c]  <= '0;
                dsh[c]  <= '0;
                q[c]    <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (frame_done) pend <= 1'b1;
            unique case (st)
                IDLE: begin
                    if (pend) begin
                        st <= FLUSH;
                    end else if (in_valid && in_ready) begin
                        for (int c = 0; c < CH; c++) begin
                            sum[c] <= sum_add[c][SUM_W] ? '1
                                    : sum_add[c][SUM_W-1:0];
                            // dividend MAXO*num, divisor aligned to the quotient MSB
                            rem[c] <= REM_W'(MAXO) * REM_W'(num[c]);
                            dsh[c] <= REM_W'(den[c]) << (OUT_W - 1);
                            q[c]   <= tm_en ? '0 : e[c][IN_W-1 -: OUT_W];
                        end
                        cnt <= '0;
                        st  <= tm_en ? DIV : PACK;
                    end
                end
                DIV: begin
                    for (int c = 0; c < CH; c++) begin
                        // a zero divisor never subtracts, so den==0 yields 0
                        if ((dsh[c] != '0) && (rem[c] >= dsh[c])) begin
                            rem[c] <= rem[c] - dsh[c];
                            q[c]   <= {q[c][OUT_W-2:0], 1'b1};
                        end else begin
                            q[c]   <= {q[c][OUT_W-2:0], 1'b0};
                        end
                        dsh[c] <= dsh[c] >> 1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(OUT_W - 1)) st <= PACK;
                end
                PACK: begin
                    hold <= hold_nx;
                    slot <= slot + 1'b1;
                    if (slot == LAST) begin
                        wr_data    <= hold_nx;
                        from_flush <= 1'b0;
                        st         <= WRITE;
                    end else begin
                        st <= IDLE;
                    end
                end
                WRITE: begin
                    if (!ram_busy) begin
                        hold <= '0;
                        slot <= '0;
                        st   <= IDLE;
                    end
                end
                FLUSH: begin
                    if (slot != '0) begin
                        wr_data    <= hold;
                        from_flush <= 1'b1;
                        st         <= WRITE;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
            if (fin) begin
                for (int c = 0; c < CH; c++) begin
                    mean[c] <= MEAN_W'(sum[c] >> LOG2_NPIX);
                    sum[c]  <= '0;
                end
                frame_cnt <= frame_cnt + 8'd1;
                pend      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tone_map_stream.sv
// tb_tone_map_stream: table vectors, directed corner sequences and random
// frames checked against a behavioural Reinhard + packing model.
`timescale 1ns/1ps
module tb_tone_map_stream;
    localparam int IN_W      = 12;
    localparam int CH        = 3;
    localparam int OUT_W     = 5;
    localparam int PIX_W     = 16;
    localparam int WORD_W    = 64;
    localparam int LOG2_NPIX = 2;
    localparam int A_Q8      = 46;
    localparam int PPW       = WORD_W / PIX_W;
    localparam longint SUM_MAX = (longint'(1) << (IN_W + LOG2_NPIX + 1)) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [CH*IN_W-1:0] in_data = '0;
    logic               in_ready;
    logic               frame_done = 1'b0;
    logic               tm_en = 1'b0;
    logic               ram_busy = 1'b0;
    logic               wr_req;
    logic [WORD_W-1:0]  wr_data;
    logic [7:0]         frame_cnt;

    tone_map_stream #(
        .IN_W(IN_W), .CH(CH), .OUT_W(OUT_W), .PIX_W(PIX_W),
        .WORD_W(WORD_W), .LOG2_NPIX(LOG2_NPIX), .A_Q8(A_Q8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .frame_done(frame_done), .tm_en(tm_en),
        .ram_busy(ram_busy), .wr_req(wr_req), .wr_data(wr_data),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit busy_rand = 1'b0;
    logic [WORD_W-1:0] got_q[$];
    logic [WORD_W-1:0] exp_q[$];

    longint            m_mean[CH];
    longint            m_sum[CH];
    int                m_slot;
    logic [WORD_W-1:0] m_word;
    int                m_fcnt;

    typedef struct {
        logic [11:0] e;
        bit          tm;
        logic [15:0] fld;
    } vec_t;
    vec_t tbl[8];

    always @(negedge clk) if (wr_req) got_q.push_back(wr_data);

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int map_ch(input longint e, input longint mean);
        longint num;
        longint den;
        num = A_Q8 * e;
        den = mean * 256 + num;
        if (den == 0) return 0;
        return int'(((2**OUT_W - 1) * num) / den);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mean[c] = 0;
            m_sum[c]  = 0;
        end
        m_slot = 0;
        m_word = '0;
        m_fcnt = 0;
        exp_q.delete();
    endtask

    task automatic model_pix(input int e0, input int e1, input int e2,
                             input bit tm);
        int ev[CH];
        int d;
        logic [PIX_W-1:0] f;
        ev[0] = e0;
        ev[1] = e1;
        ev[2] = e2;
        f = '0;
        for (int c = 0; c < CH; c++) begin
            d = tm ? map_ch(ev[c], m_mean[c]) : (ev[c] >> (IN_W - OUT_W));
            f = f | (PIX_W'(d) << (PIX_W - OUT_W * (c + 1)));
            m_sum[c] = m_sum[c] + ev[c];
            if (m_sum[c] > SUM_MAX) m_sum[c] = SUM_MAX;
        end
        m_word = m_word | (WORD_W'(f) << (PIX_W * m_slot));
        m_slot++;
        if (m_slot == PPW) begin
            exp_q.push_back(m_word);
            m_word = '0;
            m_slot = 0;
        end
    endtask

    task automatic model_fd();
        if (m_slot != 0) exp_q.push_back(m_word);
        m_word = '0;
        m_slot = 0;
        for (int c = 0; c < CH; c++) begin
            m_mean[c] = m_sum[c] >> LOG2_NPIX;
            m_sum[c]  = 0;
        end
        m_fcnt = (m_fcnt + 1) % 256;
    endtask

    task automatic send_pix(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input bit tm, input bit fd);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = {a, b, c};
        tm_en    = tm;
        in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            if (busy_rand) ram_busy = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            n++;
        end
        if (busy_rand) ram_busy = 1'b0;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 for %0d cycles", n);
        end
        frame_done = fd;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic pulse_fd();
        @(negedge clk);
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic wait_fcnt(input string name);
        int n;
        n = 0;
        while (frame_cnt !== 8'(m_fcnt) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, frame_cnt, 64'(m_fcnt));
    endtask

    task automatic drain(input string name);
        chk({name, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [WORD_W-1:0] exp_w;
        logic [11:0] r0;
        logic [11:0] r1;
        logic [11:0] r2;
        bit rt;
        bit any_wr;
        bit any_rdy;
        int np;

        tbl[0] = '{12'd400,  1'b1, 16'h2108};
        tbl[1] = '{12'd4095, 1'b1, 16'hA528};
        tbl[2] = '{12'd0,    1'b1, 16'h0000};
        tbl[3] = '{12'd400,  1'b1, 16'h2108};
        tbl[4] = '{12'hFFF,  1'b0, 16'hFFFE};
        tbl[5] = '{12'h1FF,  1'b0, 16'h18C6};
        tbl[6] = '{12'h07F,  1'b0, 16'h0000};
        tbl[7] = '{12'h800,  1'b0, 16'h8420};
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        // frame 1: mean is zero, so nonzero radiance saturates to MAXO
        for (int i = 0; i < 4; i++) begin
            send_pix(12'd400, 12'd400, 12'd400, 1'b1, 1'b0);
            model_pix(400, 400, 400, 1'b1);
        end
        pulse_fd();
        model_fd();
        wait_fcnt("f1_cnt");
        chk("f1_nwords", got_q.size(), 1);
        if (got_q.size() > 0) chk("f1_word", got_q[0], 64'hFFFE_FFFE_FFFE_FFFE);
        got_q.delete();
        exp_q.delete();

        // frame 2: table vectors with mean 400, RAM busy when the word fills
        exp_w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ram_busy = 1'b1;
            send_pix(tbl[i].e, tbl[i].e, tbl[i].e, tbl[i].tm, 1'b0);
            model_pix(tbl[i].e, tbl[i].e, tbl[i].e, tbl[i].tm);
            exp_w = exp_w | (WORD_W'(tbl[i].fld) << (PIX_W * i));
        end
        any_wr  = 1'b0;
        any_rdy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_wr  = any_wr | wr_req;
            any_rdy = any_rdy | in_ready;
        end
        chk("busy_no_wr", any_wr, 0);
        chk("busy_no_ready", any_rdy, 0);
        @(posedge clk);
        #1 ram_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_wr", wr_req, 1);
        chk("busy_release_data", wr_data, exp_w);
        @(negedge clk);
        chk("wr_single_pulse", wr_req, 0);
        pulse_fd();
        model_fd();
        wait_fcnt("f2_cnt");
        chk("f2_nwords", got_q.size(), 1);
        if (got_q.size() > 0) chk("f2_word", got_q[0], exp_w);
        got_q.delete();
        exp_q.delete();

        // partial word: two pixels then frame_done
        for (int i = 0; i < 2; i++) begin
            r0 = 12'($urandom_range(1, 4095));
            r1 = 12'($urandom_range(1, 4095));
            r2 = 12'($urandom_range(1, 4095));
            send_pix(r0, r1, r2, 1'b1, 1'b0);
            model_pix(r0, r1, r2, 1'b1);
        end
        pulse_fd();
        model_fd();
        wait_fcnt("partial_cnt");
        if (got_q.size() > 0) chk("partial_hi_zero", got_q[0][63:32], 0);
        drain("partial_word");

        // next frame restarts at slot 0
        for (int i = 0; i < 4; i++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            send_pix(r0, r1, r2, 1'b1, 1'b0);
            model_pix(r0, r1, r2, 1'b1);
        end
        pulse_fd();
        model_fd();
        wait_fcnt("restart_cnt");
        drain("restart_word");

        // bypass table vectors
        exp_w = '0;
        for (int i = 4; i < 8; i++) begin
            send_pix(tbl[i].e, tbl[i].e, tbl[i].e, tbl[i].tm, 1'b0);
            model_pix(tbl[i].e, tbl[i].e, tbl[i].e, tbl[i].tm);
            exp_w = exp_w | (WORD_W'(tbl[i].fld) << (PIX_W * (i - 4)));
        end
        pulse_fd();
        model_fd();
        wait_fcnt("bypass_cnt");
        chk("bypass_nwords", got_q.size(), 1);
        if (got_q.size() > 0) chk("bypass_word", got_q[0], exp_w);
        got_q.delete();
        exp_q.delete();

        // pixel accepted together with frame_done belongs to the ending frame
        for (int i = 0; i < 3; i++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            send_pix(r0, r1, r2, 1'b1, i == 2);
            model_pix(r0, r1, r2, 1'b1);
        end
        model_fd();
        wait_fcnt("samecyc_cnt");
        drain("samecyc_word");

        // frame_done during DIV, second pulse while pending is ignored
        send_pix(12'd1000, 12'd50, 12'd3000, 1'b1, 1'b0);
        model_pix(1000, 50, 3000, 1'b1);
        pulse_fd();
        pulse_fd();
        model_fd();
        wait_fcnt("pend_cnt");
        repeat (30) @(negedge clk);
        chk("pend_once", frame_cnt, 64'(m_fcnt));
        drain("pend_word");

        // random frames with random RAM back-pressure
        busy_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            np = $urandom_range(1, 9);
            for (int i = 0; i < np; i++) begin
                r0 = 12'($urandom_range(0, 4095));
                r1 = 12'($urandom_range(0, 4095));
                r2 = 12'($urandom_range(0, 4095));
                rt = ($urandom_range(0, 3) != 0);
                send_pix(r0, r1, r2, rt, 1'b0);
                model_pix(r0, r1, r2, rt);
            end
            pulse_fd();
            model_fd();
            wait_fcnt("rand_cnt");
            drain("rand_word");
        end
        busy_rand = 1'b0;
        ram_busy  = 1'b0;

        // reset during DIV with a partial word held
        send_pix(12'd100, 12'd200, 12'd300, 1'b1, 1'b0);
        send_pix(12'd5, 12'd6, 12'd7, 1'b1, 1'b0);
        send_pix(12'd900, 12'd900, 12'd900, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_no_wr", got_q.size(), 0);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            r0 = 12'($urandom_range(1, 4095));
            r1 = 12'($urandom_range(1, 4095));
            r2 = 12'($urandom_range(1, 4095));
            send_pix(r0, r1, r2, 1'b1, 1'b0);
            model_pix(r0, r1, r2, 1'b1);
        end
        pulse_fd();
        model_fd();
        wait_fcnt("post_rst_cnt");
        if (got_q.size() > 0)
            chk("post_rst_max", got_q[0], 64'hFFFE_FFFE_FFFE_FFFE);
        drain("post_rst_word");

        // frame counter wraps 255 -> 0 (empty frames)
        while (m_fcnt != 255) begin
            pulse_fd();
            model_fd();
            wait_fcnt("wrap_step");
        end
        pulse_fd();
        model_fd();
        wait_fcnt("wrap_zero");
        chk("wrap_no_wr", got_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
